// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and widths for the two-master SDRAM host-port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, BUSY, DONE)
//   master_idx_t : index of a requesting master (0 = CPU, 1 = display/DMA)
//   host_req_t   : one captured host request (addr, wdata, wr_en, bytesel)
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef logic master_idx_t;

    // Host address is word addressed, so bit 0 does not exist.
    typedef struct packed {
        logic [SDRAM_ADDR_W:1]   addr;
        logic [SDRAM_DATA_W-1:0] wdata;
        logic                    wr_en;
        logic [1:0]              bytesel;
    } host_req_t;

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select between two requesters.
// Build option: SDRAM_ARB_RR_EN
//   defined   : round-robin, a tie goes to the master that was not granted last
//   undefined : fixed priority, m0 beats m1; no last_grant port exists
// Ports:
//   last_grant (in, RR build only) : master granted most recently
//   req0, req1 (in)                : request lines of m0 / m1
//   any_req    (out)               : at least one master is requesting
//   winner     (out)               : selected master, meaningful when any_req
// -----------------------------------------------------------------------------
module arb_pick
    import sdram_arb_pkg::*;
(
`ifdef SDRAM_ARB_RR_EN
    input  master_idx_t last_grant,
`endif
    input  logic        req0,
    input  logic        req1,
    output logic        any_req,
    output master_idx_t winner
);

    assign any_req = req0 | req1;

`ifdef SDRAM_ARB_RR_EN
    // A lone requester always wins; only a tie looks at the history.
    assign winner = (req0 && req1) ? ~last_grant : req1;
`else
    assign winner = req1 && !req0;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Two-master arbiter in front of the SDRAM controller host port. Serialises
// m0 (CPU) and m1 (display/DMA) onto one access/cs/addr/wdata/wr_en/bytesel
// interface, one transaction in flight, all controller-side outputs registered.
// Build option: SDRAM_ARB_RR_EN selects round-robin instead of m0 priority.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   mN_access/addr/wdata/wr_en/bytesel (in) : master N request, held until ack
//   mN_ack (out)          : one-cycle completion pulse to master N
//   mN_rdata (out)        : read data with mN_ack, otherwise 0
//   s_access/cs/addr/wdata/wr_en/bytesel (out) : controller host request
//   s_compl, s_rdata (in) : controller completion and read data
//   s_config_done (in)    : controller finished SDRAM init; no grants before
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int addr_width = SDRAM_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    m0_access,
    input  logic [addr_width:1]     m0_addr,
    input  logic [SDRAM_DATA_W-1:0] m0_wdata,
    input  logic                    m0_wr_en,
    input  logic [1:0]              m0_bytesel,
    output logic                    m0_ack,
    output logic [SDRAM_DATA_W-1:0] m0_rdata,

    input  logic                    m1_access,
    input  logic [addr_width:1]     m1_addr,
    input  logic [SDRAM_DATA_W-1:0] m1_wdata,
    input  logic                    m1_wr_en,
    input  logic [1:0]              m1_bytesel,
    output logic                    m1_ack,
    output logic [SDRAM_DATA_W-1:0] m1_rdata,

    output logic                    s_access,
    output logic                    s_cs,
    output logic [addr_width:1]     s_addr,
    output logic [SDRAM_DATA_W-1:0] s_wdata,
    output logic                    s_wr_en,
    output logic [1:0]              s_bytesel,
    input  logic                    s_compl,
    input  logic [SDRAM_DATA_W-1:0] s_rdata,
    input  logic                    s_config_done
);

    arb_state_t              state_q, state_d;
    host_req_t               req_q, req_d;
    logic                    s_access_q, s_access_d;
    logic                    s_cs_q, s_cs_d;
    // Master owning the transaction in flight; doubles as last_grant for RR.
    master_idx_t             grant_q, grant_d;
    logic                    m0_ack_q, m0_ack_d;
    logic                    m1_ack_q, m1_ack_d;
    logic [SDRAM_DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [SDRAM_DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    host_req_t   m0_req, m1_req;
    logic        any_req;
    master_idx_t winner;

    assign m0_req = '{addr: m0_addr, wdata: m0_wdata, wr_en: m0_wr_en, bytesel: m0_bytesel};
    assign m1_req = '{addr: m1_addr, wdata: m1_wdata, wr_en: m1_wr_en, bytesel: m1_bytesel};

    arb_pick u_pick (
`ifdef SDRAM_ARB_RR_EN
        .last_grant (grant_q),
`endif
        .req0       (m0_access),
        .req1       (m1_access),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        req_d      = req_q;
        s_access_d = s_access_q;
        s_cs_d     = s_cs_q;
        grant_d    = grant_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = '0;
        m1_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (s_config_done && any_req) begin
                    req_d      = winner ? m1_req : m0_req;
                    s_access_d = 1'b1;
                    s_cs_d     = 1'b1;
                    grant_d    = winner;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Master requests are not looked at here; the captured copy
                // in req_q keeps the controller inputs stable.
                if (s_compl) begin
                    if (grant_q) begin
                        m1_ack_d   = 1'b1;
                        m1_rdata_d = req_q.wr_en ? '0 : s_rdata;
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_rdata_d = req_q.wr_en ? '0 : s_rdata;
                    end
                    s_access_d = 1'b0;
                    s_cs_d     = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // Dead cycle: the acked master gets to drop or advance its
                // request before IDLE samples again.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            state_q    <= IDLE;
            req_q      <= '0;
            s_access_q <= 1'b0;
            s_cs_q     <= 1'b0;
            grant_q    <= 1'b1;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            s_access_q <= s_access_d;
            s_cs_q     <= s_cs_d;
            grant_q    <= grant_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign s_access  = s_access_q;
    assign s_cs      = s_cs_q;
    assign s_addr    = req_q.addr;
    assign s_wdata   = req_q.wdata;
    assign s_wr_en   = req_q.wr_en;
    assign s_bytesel = req_q.bytesel;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. Two master agents present queued requests
// and advance on ack, a controller model answers with s_compl after a set
// latency (read data = rdata_base ^ low 16 address bits), and a monitor checks
// every grant and every ack against queues of expected results.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    typedef struct packed {
        logic        mst;
        logic [15:0] rdata;
    } exp_ack_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_access, m1_access;
    logic [25:1] m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_wr_en, m1_wr_en;
    logic [1:0]  m0_bytesel, m1_bytesel;
    logic        m0_ack, m1_ack;
    logic [15:0] m0_rdata, m1_rdata;
    logic        s_access, s_cs, s_wr_en, s_compl, s_config_done;
    logic [25:1] s_addr;
    logic [15:0] s_wdata, s_rdata;
    logic [1:0]  s_bytesel;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m0_access     (m0_access),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_wr_en      (m0_wr_en),
        .m0_bytesel    (m0_bytesel),
        .m0_ack        (m0_ack),
        .m0_rdata      (m0_rdata),
        .m1_access     (m1_access),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_wr_en      (m1_wr_en),
        .m1_bytesel    (m1_bytesel),
        .m1_ack        (m1_ack),
        .m1_rdata      (m1_rdata),
        .s_access      (s_access),
        .s_cs          (s_cs),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_wr_en       (s_wr_en),
        .s_bytesel     (s_bytesel),
        .s_compl       (s_compl),
        .s_rdata       (s_rdata),
        .s_config_done (s_config_done)
    );

    host_req_t m0_q[$], m1_q[$], exp_grant_q[$];
    exp_ack_t  exp_ack_q[$];
    int        total = 0;
    int        bad   = 0;

    int          slave_lat    = 4;
    logic [15:0] rdata_base   = 16'h0000;
    bit          spurious_req = 1'b0;
    int          lat_cnt      = 0;
    bit          p0 = 1'b0, p1 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input bit mst, input host_req_t r);
        if (mst) m1_q.push_back(r);
        else     m0_q.push_back(r);
    endtask

    task automatic expect_txn(input bit mst, input host_req_t r, input logic [15:0] exp_rd);
        exp_ack_t e;
        e.mst   = mst;
        e.rdata = exp_rd;
        exp_grant_q.push_back(r);
        exp_ack_q.push_back(e);
    endtask

    function automatic host_req_t mk(input logic [24:0] addr, input logic [15:0] wdata,
                                     input bit wr, input logic [1:0] bs);
        host_req_t r;
        r.addr    = addr;
        r.wdata   = wdata;
        r.wr_en   = wr;
        r.bytesel = bs;
        return r;
    endfunction

    task automatic issue(input bit mst, input host_req_t r, input logic [15:0] exp_rd);
        push_req(mst, r);
        expect_txn(mst, r, exp_rd);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((m0_q.size() != 0 || m1_q.size() != 0 || exp_ack_q.size() != 0 || s_access) && n < budget) begin
            tick();
            n++;
        end
        check(name, n < budget, 1'b1);
        repeat (3) tick();
    endtask

    task automatic wait_access(input string name, input int budget);
        int n = 0;
        while (!s_access && n < budget) begin
            tick();
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_access"}, s_access, 0);
        check({tag, "_s_cs"}, s_cs, 0);
        check({tag, "_s_addr"}, s_addr, 0);
        check({tag, "_s_wdata"}, s_wdata, 0);
        check({tag, "_s_wr_en"}, s_wr_en, 0);
        check({tag, "_s_bytesel"}, s_bytesel, 0);
        check({tag, "_acks"}, {m1_ack, m0_ack}, 0);
        check({tag, "_rdata"}, {m1_rdata, m0_rdata}, 0);
    endtask

    // Master agents: present the queue head, retire it on ack.
    initial begin
        m0_access = 0; m0_addr = '0; m0_wdata = '0; m0_wr_en = 0; m0_bytesel = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m0_ack && p0) begin
                void'(m0_q.pop_front());
                p0 = 1'b0;
                m0_access = 1'b0;
            end
            if (!p0 && m0_q.size() != 0) begin
                {m0_addr, m0_wdata, m0_wr_en, m0_bytesel} = m0_q[0];
                m0_access = 1'b1;
                p0 = 1'b1;
            end
        end
    end

    initial begin
        m1_access = 0; m1_addr = '0; m1_wdata = '0; m1_wr_en = 0; m1_bytesel = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m1_ack && p1) begin
                void'(m1_q.pop_front());
                p1 = 1'b0;
                m1_access = 1'b0;
            end
            if (!p1 && m1_q.size() != 0) begin
                {m1_addr, m1_wdata, m1_wr_en, m1_bytesel} = m1_q[0];
                m1_access = 1'b1;
                p1 = 1'b1;
            end
        end
    end

    // Controller model.
    initial begin
        s_compl = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            s_compl = 1'b0;
            s_rdata = '0;
            if (spurious_req) begin
                s_compl      = 1'b1;
                s_rdata      = 16'hFFFF;
                spurious_req = 1'b0;
            end else if (s_access) begin
                if (lat_cnt >= slave_lat) begin
                    s_compl = 1'b1;
                    s_rdata = rdata_base ^ s_addr[16:1];
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor / scoreboard.
    logic        prev_access = 1'b0;
    logic        prev_compl  = 1'b0;
    logic [43:0] prev_fields = '0;
    int          gap         = 0;
    bit          seen_grant  = 1'b0;

    always @(negedge clk) begin
        host_req_t g;
        exp_ack_t  e;
        if (!reset_n) begin
            prev_access = 1'b0;
            prev_compl  = 1'b0;
            seen_grant  = 1'b0;
            gap         = 0;
        end else begin
            if (s_access && !prev_access) begin
                if (seen_grant) check("grant_gap_ge2", gap >= 2, 1'b1);
                if (exp_grant_q.size() == 0) begin
                    check("unexpected_grant", s_access, 0);
                end else begin
                    g = exp_grant_q.pop_front();
                    check("grant_addr", s_addr, g.addr);
                    check("grant_wdata", s_wdata, g.wdata);
                    check("grant_wr_en", s_wr_en, g.wr_en);
                    check("grant_bytesel", s_bytesel, g.bytesel);
                    check("grant_cs", s_cs, 1'b1);
                end
                seen_grant = 1'b1;
            end
            if (s_access && prev_access)
                check("busy_fields_stable", {s_addr, s_wdata, s_wr_en, s_bytesel}, prev_fields);
            gap = s_access ? 0 : gap + 1;

            check("acks_exclusive", m0_ack & m1_ack, 1'b0);
            if (!m0_ack) check("m0_rdata_idle_zero", m0_rdata, 0);
            if (!m1_ack) check("m1_rdata_idle_zero", m1_rdata, 0);
            if (m0_ack || m1_ack) begin
                check("ack_one_after_compl", prev_compl, 1'b1);
                if (exp_ack_q.size() == 0) begin
                    check("unexpected_ack", {m1_ack, m0_ack}, 0);
                end else begin
                    e = exp_ack_q.pop_front();
                    check("ack_master", {m1_ack, m0_ack}, e.mst ? 2'b10 : 2'b01);
                    check("ack_rdata", e.mst ? m1_rdata : m0_rdata, e.rdata);
                end
            end
            prev_access = s_access;
            prev_compl  = s_compl;
            prev_fields = {s_addr, s_wdata, s_wr_en, s_bytesel};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        s_config_done = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");

        // Config gating: request waits for s_config_done.
        reset_n = 1'b1;
        issue(1'b0, mk(25'h0000100, 16'h0, 1'b0, 2'b11), 16'h0100);
        repeat (8) begin
            tick();
            check("gated_no_access", s_access, 1'b0);
        end
        s_config_done = 1'b1;
        tick();
        check("config_grant_access", s_access, 1'b1);
        check("config_grant_addr", s_addr, 25'h0000100);
        wait_idle("gating_done", 50);

        // Single read, controller returns 0xBEEF.
        slave_lat  = 4;
        rdata_base = 16'hBEEF ^ 16'h4567;
        issue(1'b0, mk(25'h1234567, 16'h0, 1'b0, 2'b11), 16'hBEEF);
        wait_idle("read_done", 50);
        rdata_base = 16'h0000;

        // Write from m1: rdata must come back 0 despite controller data.
        rdata_base = 16'hDEAD;
        issue(1'b1, mk(25'h0000002, 16'hA55A, 1'b1, 2'b01), 16'h0000);
        wait_idle("write_done", 50);
        rdata_base = 16'h0000;

        // Contention: both masters queue 4 reads at once.
        slave_lat = 2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, mk(25'h10 + 25'(i), 16'h0, 1'b0, 2'b11));
            push_req(1'b1, mk(25'h20 + 25'(i), 16'h0, 1'b0, 2'b11));
        end
`ifdef SDRAM_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            expect_txn(1'b0, mk(25'h10 + 25'(i), 16'h0, 1'b0, 2'b11), 16'h0010 + 16'(i));
            expect_txn(1'b1, mk(25'h20 + 25'(i), 16'h0, 1'b0, 2'b11), 16'h0020 + 16'(i));
        end
`else
        for (int i = 0; i < 4; i++)
            expect_txn(1'b0, mk(25'h10 + 25'(i), 16'h0, 1'b0, 2'b11), 16'h0010 + 16'(i));
        for (int i = 0; i < 4; i++)
            expect_txn(1'b1, mk(25'h20 + 25'(i), 16'h0, 1'b0, 2'b11), 16'h0020 + 16'(i));
`endif
        wait_idle("contention_done", 300);

        // Stability: m1 changes its address while BUSY.
        slave_lat = 6;
        issue(1'b1, mk(25'h0000ABC, 16'h0, 1'b0, 2'b10), 16'h0ABC);
        wait_access("stab_grant_seen", 20);
        tick();
        m1_addr = 25'h1FFFFFF;
        tick();
        check("busy_addr_held", s_addr, 25'h0000ABC);
        wait_idle("stab_done", 50);

        // Spurious s_compl while IDLE.
        spurious_req = 1'b1;
        repeat (4) begin
            tick();
            check("spurious_no_ack", {m1_ack, m0_ack}, 0);
            check("spurious_no_access", s_access, 1'b0);
        end

        // Reset during BUSY: transaction abandoned, then re-granted once.
        slave_lat = 10;
        issue(1'b0, mk(25'h0000777, 16'h1234, 1'b0, 2'b11), 16'h0777);
        exp_grant_q.push_back(mk(25'h0000777, 16'h1234, 1'b0, 2'b11));
        wait_access("rst_grant_seen", 20);
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        check_all_zero("midop_reset");
        tick();
        reset_n = 1'b1;
        wait_idle("rst_regrant_done", 100);

        check("grants_consumed", exp_grant_q.size(), 0);
        check("acks_consumed", exp_ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
